// File: rtl/keyword_stream_scheduler.sv
// keyword_stream_scheduler
// Shares one keyword classifier between NUM_CH feature sources. A round-robin
// arbiter issues feature words, and an in-order tag FIFO records the channel of
// each issued word. Classifier results are routed back to that channel.
module keyword_stream_scheduler #(
   parameter int NUM_CH    = 2,
   parameter int FEAT_W    = 40,
   parameter int TAG_DEPTH = 4,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int AW       = $clog2(TAG_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        ch_valid,
   output logic [NUM_CH-1:0]        ch_ready,
   input  logic [NUM_CH*FEAT_W-1:0] ch_feature,
   output logic                     fin_valid,
   input  logic                     fin_ready,
   output logic [FEAT_W-1:0]        fin_feature,
   input  logic                     dout_valid,
   output logic                     dout_ready,
   input  logic [3:0]               keyword,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [3:0]               res_keyword,
   output logic [CH_W-1:0]          res_ch,
   output logic [AW:0]              inflight,
   output logic                     orphan_err
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state_reg, state_next;
   logic [CH_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [CH_W-1:0]   lock_reg, lock_next;
   logic [CH_W-1:0]   grant;
   logic [CH_W-1:0]   search_idx;
   logic              search_found;
   logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
   logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]       count_reg;
   logic              full, empty, push, pop, orphan_set;
   logic [FEAT_W-1:0] feat_arr [NUM_CH];

   // Unflatten the per-channel feature bus.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_feat
         assign feat_arr[gi] = ch_feature[gi*FEAT_W +: FEAT_W];
      end
   endgenerate

   assign full     = (count_reg == (AW+1)'(TAG_DEPTH));
   assign empty    = (count_reg == '0);
   assign inflight = count_reg;

   // Round-robin search: first valid channel at or after rr_ptr, with wrap.
   // Scanning from the farthest offset down lets the nearest one win.
   always_comb begin
      int idx;
      idx          = 0;
      search_found = 1'b0;
      search_idx   = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr_reg) + k) % NUM_CH;
         if (ch_valid[CH_W'(idx)]) begin
            search_found = 1'b1;
            search_idx   = CH_W'(idx);
         end
      end
   end

   // Arbiter FSM: next state, grant and issue-side outputs. All outputs are
   // forced to zero while reset is held so they clear without a clock edge.
   always_comb begin
      state_next  = state_reg;
      lock_next   = lock_reg;
      rr_ptr_next = rr_ptr_reg;
      grant       = search_idx;
      fin_valid   = 1'b0;
      case (state_reg)
         IDLE: begin
            grant     = search_idx;
            fin_valid = !full && search_found;
         end
         LOCKED: begin
            grant     = lock_reg;
            fin_valid = 1'b1;
         end
         default: begin
            grant     = search_idx;
            fin_valid = 1'b0;
         end
      endcase
      if (!rst_n) begin
         fin_valid = 1'b0;
      end
      push        = fin_valid && fin_ready;
      fin_feature = fin_valid ? feat_arr[grant] : '0;
      ch_ready    = '0;
      if (fin_valid) begin
         ch_ready[grant] = fin_ready;
      end
      if (push) begin
         state_next  = IDLE;
         rr_ptr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(grant + 1'b1);
      end else if (fin_valid) begin
         state_next = LOCKED;
         lock_next  = grant;
      end
   end

   // Result routing: zero-latency pass-through tagged with the FIFO head;
   // results with no outstanding tag are swallowed and flagged.
   always_comb begin
      res_valid   = 1'b0;
      dout_ready  = 1'b0;
      res_keyword = '0;
      res_ch      = '0;
      orphan_set  = 1'b0;
      pop         = 1'b0;
      if (rst_n) begin
         if (!empty) begin
            res_valid   = dout_valid;
            dout_ready  = res_ready;
            res_keyword = keyword;
            res_ch      = tag_mem[rd_ptr_reg];
            pop         = dout_valid && res_ready;
         end else begin
            dout_ready = dout_valid;
            orphan_set = dout_valid;
         end
      end
   end

   // Tag storage: plain array, written at issue, read at the head pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wr_ptr_reg] <= grant;
      end
   end

   // Control state: arbiter, FIFO pointers/occupancy and the sticky orphan flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         lock_reg   <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         orphan_err <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         lock_reg   <= lock_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (orphan_set) begin
            orphan_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_keyword_stream_scheduler.sv
// Self-checking bench for keyword_stream_scheduler (NUM_CH=2, TAG_DEPTH=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_keyword_stream_scheduler;

   localparam int NUM_CH    = 2;
   localparam int FEAT_W    = 40;
   localparam int TAG_DEPTH = 4;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH-1:0]        ch_ready;
   logic [NUM_CH*FEAT_W-1:0] ch_feature;
   logic                     fin_valid;
   logic                     fin_ready;
   logic [FEAT_W-1:0]        fin_feature;
   logic                     dout_valid;
   logic                     dout_ready;
   logic [3:0]               keyword;
   logic                     res_valid;
   logic                     res_ready;
   logic [3:0]               res_keyword;
   logic [0:0]               res_ch;
   logic [2:0]               inflight;
   logic                     orphan_err;

   int checks = 0;
   int errors = 0;

   keyword_stream_scheduler #(
      .NUM_CH(NUM_CH), .FEAT_W(FEAT_W), .TAG_DEPTH(TAG_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_feature(ch_feature),
      .fin_valid(fin_valid), .fin_ready(fin_ready), .fin_feature(fin_feature),
      .dout_valid(dout_valid), .dout_ready(dout_ready), .keyword(keyword),
      .res_valid(res_valid), .res_ready(res_ready), .res_keyword(res_keyword),
      .res_ch(res_ch), .inflight(inflight), .orphan_err(orphan_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] cv;
      logic       frdy;
      logic       dv;
      logic [3:0] kw;
      logic       rrdy;
      logic       fv;
      logic [1:0] crdy;
      logic [1:0] fsel;   // 0: zero, 1: ch0 word, 2: ch1 word
      logic       drdy;
      logic       rv;
      logic       rch;
      logic [3:0] rkw;
      logic [2:0] infl;
      logic       orph;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(input logic [1:0] cv, input logic frdy, input logic dv,
                               input logic [3:0] kw, input logic rrdy, input logic fv,
                               input logic [1:0] crdy, input logic [1:0] fsel,
                               input logic drdy, input logic rv, input logic rch,
                               input logic [3:0] rkw, input logic [2:0] infl,
                               input logic orph);
      vec_t v;
      v.cv = cv; v.frdy = frdy; v.dv = dv; v.kw = kw; v.rrdy = rrdy;
      v.fv = fv; v.crdy = crdy; v.fsel = fsel; v.drdy = drdy; v.rv = rv;
      v.rch = rch; v.rkw = rkw; v.infl = infl; v.orph = orph;
      return v;
   endfunction

   function automatic logic [63:0] obs_all();
      return 64'({fin_valid, ch_ready, fin_feature, dout_ready, res_valid,
                  res_ch, res_keyword, inflight, orphan_err});
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end else begin
         $display("ok   %s value=%h", name, act);
      end
   endtask

   task automatic drv(input logic [1:0] cv, input logic [FEAT_W-1:0] f0,
                      input logic [FEAT_W-1:0] f1, input logic frdy, input logic dv,
                      input logic [3:0] kw, input logic rrdy);
      ch_valid   = cv;
      ch_feature = {f1, f0};
      fin_ready  = frdy;
      dout_valid = dv;
      keyword    = kw;
      res_ready  = rrdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drv(2'b00, '0, '0, 1'b0, 1'b0, 4'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      logic [FEAT_W-1:0] f0, f1, ef;
      logic [FEAT_W-1:0] words [5];
      int exp_infl;
      int peak;

      // Issue / result sequence from reset, cycle by cycle.
      //            cv    fr dv kw rr | fv crdy  fs dr rv rc rkw in or
      tbl[0]  = mk(2'b11, 1, 0, 0, 1,   1, 2'b01, 1, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(2'b11, 1, 0, 0, 1,   1, 2'b10, 2, 1, 0, 0, 0, 1, 0);
      tbl[2]  = mk(2'b11, 1, 0, 0, 1,   1, 2'b01, 1, 1, 0, 0, 0, 2, 0);
      tbl[3]  = mk(2'b11, 1, 0, 0, 1,   1, 2'b10, 2, 1, 0, 0, 0, 3, 0);
      tbl[4]  = mk(2'b11, 1, 1, 5, 1,   0, 2'b00, 0, 1, 1, 0, 5, 4, 0);
      tbl[5]  = mk(2'b11, 1, 0, 0, 1,   1, 2'b01, 1, 1, 0, 1, 0, 3, 0);
      tbl[6]  = mk(2'b11, 1, 1, 9, 1,   0, 2'b00, 0, 1, 1, 1, 9, 4, 0);
      tbl[7]  = mk(2'b11, 0, 1, 3, 0,   1, 2'b00, 2, 0, 1, 0, 3, 3, 0);
      tbl[8]  = mk(2'b10, 1, 1, 4, 1,   1, 2'b10, 2, 1, 1, 0, 4, 3, 0);
      tbl[9]  = mk(2'b00, 1, 1, 6, 1,   0, 2'b00, 0, 1, 1, 1, 6, 3, 0);
      tbl[10] = mk(2'b00, 1, 1, 7, 1,   0, 2'b00, 0, 1, 1, 0, 7, 2, 0);
      tbl[11] = mk(2'b00, 1, 1, 8, 1,   0, 2'b00, 0, 1, 1, 1, 8, 1, 0);
      tbl[12] = mk(2'b00, 1, 1, 2, 1,   0, 2'b00, 0, 1, 0, 0, 0, 0, 0);
      tbl[13] = mk(2'b00, 1, 0, 0, 1,   0, 2'b00, 0, 0, 0, 0, 0, 0, 1);
      tbl[14] = mk(2'b01, 1, 0, 0, 1,   1, 2'b01, 1, 0, 0, 0, 0, 0, 1);

      // Reset held with busy inputs: every output must read as its reset value.
      rst_n = 1'b0;
      drv(2'b11, 40'hA0_0000_0001, 40'hB1_0000_0001, 1'b1, 1'b1, 4'd7, 1'b1);
      #2;
      chk("reset_outputs", obs_all(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drv(2'b00, '0, '0, 1'b0, 1'b0, 4'd0, 1'b0);
      step();

      for (int r = 0; r < 15; r++) begin
         f0 = 40'hA0_0000_0000 | FEAT_W'(r);
         f1 = 40'hB1_0000_0000 | FEAT_W'(r);
         drv(tbl[r].cv, f0, f1, tbl[r].frdy, tbl[r].dv, tbl[r].kw, tbl[r].rrdy);
         ef = (tbl[r].fsel == 2'd1) ? f0 : (tbl[r].fsel == 2'd2) ? f1 : '0;
         @(negedge clk);
         chk($sformatf("row%0d", r), obs_all(),
             64'({tbl[r].fv, tbl[r].crdy, ef, tbl[r].drdy, tbl[r].rv, tbl[r].rch,
                  tbl[r].rkw, tbl[r].infl, tbl[r].orph}));
         step();
      end

      // Single channel: 5 back-to-back words, each result 3 cycles after issue.
      do_reset();
      for (int i = 0; i < 5; i++) words[i] = 40'h55_0000_0000 + FEAT_W'(i * 16'h1234);
      exp_infl = 0;
      peak     = 0;
      for (int c = 0; c < 11; c++) begin
         drv((c < 5) ? 2'b01 : 2'b00, (c < 5) ? words[c] : '0, '0, 1'b1,
             (c >= 3 && c < 8), (c >= 3 && c < 8) ? 4'(c - 3) : 4'd0, 1'b1);
         @(negedge clk);
         chk($sformatf("single_infl_c%0d", c), 64'(inflight), 64'(exp_infl));
         if (int'(inflight) > peak) peak = int'(inflight);
         if (c < 5)
            chk($sformatf("single_issue_c%0d", c), 64'({fin_valid, ch_ready, fin_feature}),
                64'({1'b1, 2'b01, words[c]}));
         if (c >= 3 && c < 8)
            chk($sformatf("single_result_c%0d", c), 64'({res_valid, res_ch, res_keyword}),
                64'({1'b1, 1'b0, 4'(c - 3)}));
         exp_infl = exp_infl + ((c < 5) ? 1 : 0) - ((c >= 3 && c < 8) ? 1 : 0);
         step();
      end
      chk("single_peak_inflight", 64'(peak), 64'd3);

      // Backpressure lock: ch1 granted while ch0 is otherwise next in line.
      do_reset();
      for (int c = 0; c < 6; c++) begin
         drv((c == 0) ? 2'b10 : 2'b11, 40'hC0_0000_00C0, 40'hC1_0000_00C1,
             (c >= 4), 1'b0, 4'd0, 1'b1);
         @(negedge clk);
         if (c < 4)
            chk($sformatf("lock_hold_c%0d", c), 64'({fin_valid, ch_ready, fin_feature}),
                64'({1'b1, 2'b00, 40'hC1_0000_00C1}));
         else if (c == 4)
            chk("lock_release_ch1", 64'({fin_valid, ch_ready, fin_feature}),
                64'({1'b1, 2'b10, 40'hC1_0000_00C1}));
         else
            chk("lock_next_ch0", 64'({fin_valid, ch_ready, fin_feature}),
                64'({1'b1, 2'b01, 40'hC0_0000_00C0}));
         step();
      end

      // Reset mid-flight with two tags outstanding.
      drv(2'b11, 40'hD0_0000_0000, 40'hD1_0000_0000, 1'b0, 1'b0, 4'd0, 1'b1);
      @(negedge clk);
      chk("midflight_infl", 64'(inflight), 64'd2);
      drv(2'b11, 40'hD0_0000_0000, 40'hD1_0000_0000, 1'b1, 1'b1, 4'd9, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midflight_reset_outputs", obs_all(), 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drv(2'b00, '0, '0, 1'b1, 1'b0, 4'd0, 1'b1);
      step();
      drv(2'b00, '0, '0, 1'b1, 1'b1, 4'd9, 1'b1);
      @(negedge clk);
      chk("post_reset_drop", 64'({dout_ready, res_valid, orphan_err}), 64'(3'b100));
      step();
      drv(2'b00, '0, '0, 1'b1, 1'b0, 4'd0, 1'b1);
      @(negedge clk);
      chk("post_reset_orphan", 64'(orphan_err), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
